// File: rtl/openram_sram_responder.sv
// Cycle-accurate stand-in for an OpenRAM SRAM macro: strobe decode, single-port writes,
// pipelined reads, sticky protocol/address error flags and saturating access counters.
module openram_sram_responder #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              csb,
  input  logic              web,
  input  logic              oeb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  output logic              protoErr,
  output logic              addrErr,
  output logic [CNT_W-1:0]  readCount,
  output logic [CNT_W-1:0]  writeCount
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST  = READ_LATENCY - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic                                 w_inRange;
  logic [IDX_W-1:0]                     w_idx;
  logic                                 w_wrReq;
  logic                                 w_rdReq;
  logic                                 w_illegal;
  logic                                 w_wrDo;
  logic [DATA_W-1:0]                    w_rdData;

  logic [READ_LATENCY-1:0]              r_vldPipe;
  logic [READ_LATENCY-1:0][DATA_W-1:0]  r_datPipe;
  logic [DATA_W-1:0]                    r_dataOut;
  logic                                 r_dataValid;
  logic                                 r_protoErr;
  logic                                 r_addrErr;
  logic [CNT_W-1:0]                     r_readCount;
  logic [CNT_W-1:0]                     r_writeCount;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  assign w_inRange = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
  assign w_idx     = addr[IDX_W-1:0];

  // 000 still writes but never issues a read.
  assign w_wrReq   = !csb && !web;
  assign w_rdReq   = !csb && web && !oeb;
  assign w_illegal = !csb && !web && !oeb;
  assign w_wrDo    = w_wrReq && w_inRange;
  assign w_rdData  = w_inRange ? r_mem[w_idx] : '0;

  // Array has no reset; reset only suppresses a same-cycle write.
  always_ff @(posedge clk) begin
    if (nReset && w_wrDo)
      r_mem[w_idx] <= dataIn;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_vldPipe <= '0;
      r_datPipe <= '0;
    end else begin
      r_vldPipe[0] <= w_rdReq;
      r_datPipe[0] <= w_rdData;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vldPipe[i] <= r_vldPipe[i-1];
        r_datPipe[i] <= r_datPipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_dataOut    <= '0;
      r_dataValid  <= 1'b0;
      r_protoErr   <= 1'b0;
      r_addrErr    <= 1'b0;
      r_readCount  <= '0;
      r_writeCount <= '0;
    end else begin
      r_dataValid <= r_vldPipe[LAST];
      if (r_vldPipe[LAST]) begin
        r_dataOut <= r_datPipe[LAST];
        if (r_readCount != '1)
          r_readCount <= r_readCount + 1'b1;
      end
      if (w_wrDo && (r_writeCount != '1))
        r_writeCount <= r_writeCount + 1'b1;
      if (w_illegal)
        r_protoErr <= 1'b1;
      if ((w_wrReq || w_rdReq) && !w_inRange)
        r_addrErr <= 1'b1;
    end
  end

  assign dataOut    = r_dataOut;
  assign dataValid  = r_dataValid;
  assign protoErr   = r_protoErr;
  assign addrErr    = r_addrErr;
  assign readCount  = r_readCount;
  assign writeCount = r_writeCount;

endmodule

// File: tb/tb_openram_sram_responder.sv
// Directed bench: three responder instances (latency 2, latency 3, 4-bit counters)
// share one stimulus stream; each check targets the instance it is about.
module tb_openram_sram_responder;

  logic        clk = 1'b0;
  logic        nReset;
  logic        csb, web, oeb;
  logic [15:0] addr;
  logic [31:0] dataIn;

  logic [31:0] d2_dout, d3_dout, d4_dout;
  logic        d2_vld, d3_vld, d4_vld;
  logic        d2_perr, d3_perr, d4_perr;
  logic        d2_aerr, d3_aerr, d4_aerr;
  logic [15:0] d2_rc, d2_wc, d3_rc, d3_wc;
  logic [3:0]  d4_rc, d4_wc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  openram_sram_responder #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .nReset(nReset), .csb(csb), .web(web), .oeb(oeb), .addr(addr), .dataIn(dataIn),
    .dataOut(d2_dout), .dataValid(d2_vld), .protoErr(d2_perr), .addrErr(d2_aerr),
    .readCount(d2_rc), .writeCount(d2_wc));

  openram_sram_responder #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .nReset(nReset), .csb(csb), .web(web), .oeb(oeb), .addr(addr), .dataIn(dataIn),
    .dataOut(d3_dout), .dataValid(d3_vld), .protoErr(d3_perr), .addrErr(d3_aerr),
    .readCount(d3_rc), .writeCount(d3_wc));

  openram_sram_responder #(.READ_LATENCY(1), .CNT_W(4)) u_dut4 (
    .clk(clk), .nReset(nReset), .csb(csb), .web(web), .oeb(oeb), .addr(addr), .dataIn(dataIn),
    .dataOut(d4_dout), .dataValid(d4_vld), .protoErr(d4_perr), .addrErr(d4_aerr),
    .readCount(d4_rc), .writeCount(d4_wc));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic o,
                       input logic [15:0] a, input logic [31:0] d);
    csb = c; web = w; oeb = o; addr = a; dataIn = d;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d); drive(0, 0, 1, a, d); endtask
  task automatic rd(input logic [15:0] a);                       drive(0, 1, 0, a, '0); endtask
  task automatic idle();                                         drive(1, 1, 1, '0, '0); endtask

  initial begin
    nReset = 1'b0;
    idle();
    tick(); tick();
    chk("rst_dout", d2_dout, 0);
    chk("rst_vld",  d2_vld,  0);
    chk("rst_perr", d2_perr, 0);
    chk("rst_aerr", d2_aerr, 0);
    chk("rst_rc",   d2_rc,   0);
    chk("rst_wc",   d2_wc,   0);
    nReset = 1'b1;

    // 1: single write then latency-2 read
    wr(16'h0010, 32'hDEAD_BEEF); tick();
    chk("t1_wc", d2_wc, 1);
    rd(16'h0010); tick();
    idle();
    chk("t1_vld_e0", d2_vld, 0);
    tick();
    chk("t1_vld_e1", d2_vld, 0);
    tick();
    chk("t1_vld_e2",  d2_vld,  1);
    chk("t1_dout",    d2_dout, 32'hDEAD_BEEF);
    chk("t1_rc",      d2_rc,   1);
    tick();
    chk("t1_vld_drop", d2_vld,  0);
    chk("t1_dout_hold", d2_dout, 32'hDEAD_BEEF);

    // 2: eight writes, eight back-to-back reads
    for (int i = 0; i < 8; i++) begin
      wr(16'(i), 32'(i * 3)); tick();
    end
    for (int k = 0; k < 10; k++) begin
      if (k < 8) rd(16'(k)); else idle();
      tick();
      if (k < 2) chk($sformatf("t2_vld_pre%0d", k), d2_vld, 0);
      else begin
        chk($sformatf("t2_vld%0d", k - 2), d2_vld, 1);
        chk($sformatf("t2_dout%0d", k - 2), d2_dout, 64'((k - 2) * 3));
      end
    end
    chk("t2_rc", d2_rc, 9);
    chk("t2_wc", d2_wc, 9);

    // 3: illegal 000 strobe still writes, never reads
    drive(0, 0, 0, 16'd5, 32'h0000_00A5); tick();
    idle();
    chk("t3_perr", d2_perr, 1);
    chk("t3_wc",   d2_wc,   10);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_novld%0d", k), d2_vld, 0);
    end
    rd(16'd5); tick(); idle(); tick(); tick();
    chk("t3_vld",  d2_vld,  1);
    chk("t3_dout", d2_dout, 32'h0000_00A5);
    chk("t3_rc",   d2_rc,   10);

    // 4: out-of-range write/read; index would alias to address 0
    wr(16'd0, 32'h55AA_55AA); tick();
    chk("t4_aerr_pre", d2_aerr, 0);
    wr(16'h0400, 32'h1234_5678); tick();
    chk("t4_aerr", d2_aerr, 1);
    chk("t4_wc",   d2_wc,   11);
    rd(16'h0400); tick(); idle(); tick(); tick();
    chk("t4_vld",  d2_vld,  1);
    chk("t4_dout", d2_dout, 0);
    rd(16'd0); tick(); idle(); tick(); tick();
    chk("t4_mem0", d2_dout, 32'h55AA_55AA);
    chk("t4_rc",   d2_rc,   12);
    chk("t4_perr_sticky", d2_perr, 1);
    chk("t4_aerr_sticky", d2_aerr, 1);

    // 5: reset one edge after a latency-3 read flushes it
    rd(16'h0010); tick();
    nReset = 1'b0; idle(); tick();
    nReset = 1'b1;
    chk("t5_perr_clr", d2_perr, 0);
    chk("t5_aerr_clr", d2_aerr, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t5_novld%0d", k), d3_vld, 0);
      tick();
    end
    chk("t5_dout", d3_dout, 0);
    chk("t5_rc",   d3_rc,   0);
    chk("t5_wc",   d3_wc,   0);
    rd(16'h0010); tick(); idle();
    tick();
    chk("t5_vld_e1", d3_vld, 0);
    tick();
    chk("t5_vld_e2", d3_vld, 0);
    tick();
    chk("t5_vld_e3", d3_vld,  1);
    chk("t5_dout2",  d3_dout, 32'hDEAD_BEEF);
    chk("t5_rc2",    d3_rc,   1);

    // 6: 4-bit counters saturate; deselected write does nothing
    nReset = 1'b0; tick(); nReset = 1'b1;
    wr(16'd30, 32'h77); tick();
    wr(16'd31, 32'h1);  tick();
    wr(16'd32, 32'h2);  tick();
    chk("t6_wc3", d4_wc, 3);
    drive(1, 0, 1, 16'd30, 32'hBAD); tick();
    chk("t6_nocs_wc", d4_wc, 3);
    rd(16'd30); tick(); idle(); tick();
    chk("t6_vld",  d4_vld,  1);
    chk("t6_dout", d4_dout, 32'h77);
    chk("t6_rc",   d4_rc,   1);
    for (int i = 0; i < 12; i++) begin
      wr(16'(40 + i), 32'(i)); tick();
    end
    chk("t6_wc15", d4_wc, 4'hF);
    for (int i = 0; i < 5; i++) begin
      wr(16'(60 + i), 32'(i)); tick();
    end
    idle();
    chk("t6_wc_sat", d4_wc, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
